mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4:1 word multiplexer (mux4_1 family).
- Four requesters compete for one output channel. The block picks a winner, drives the mux select, and captures the selected word into an output register.
- It presents the word downstream with a valid/ready handshake.
- It sits between four producer ports and a single consumer, for example a shared bus or UART transmit path.

Parameters:
Width, 4, data width of each input word and of ou1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  4  per-requester valid; req[k] means ink holds a word.
in1  input  Width  requester 0 data.
in2  input  Width  requester 1 data.
in3  input  Width  requester 2 data.
in4  input  Width  requester 3 data.
in_ready  output  4  one-hot accept pulse; word k is consumed in the cycle in_ready[k]=1.
ou1  output  Width  registered output word.
out_valid  output  1  ou1 is valid.
out_ready  input  1  consumer accepts ou1 when out_valid=1.
sel  output  2  index of the current or last granted requester (registered).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ou1=0, out_valid=0, sel=2'd3.
  - Round-robin pointer last=2'd3, so requester 0 has top priority first.
  - in_ready=0.
  - Any word in flight is dropped.
- Winner selection (combinational): scan req starting at index (last+1) mod 4 and wrap around 3->0. The first set bit wins, so {0,1,2,3} is the scan order when last=3.
- States: IDLE and BUSY.
- IDLE:
  - out_valid=0.
  - If req!=0: in_ready[w]=1 this cycle; on the clock edge ou1<=in(w), sel<=w, last<=w, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - out_valid=1. ou1 and sel are held stable while out_ready=0; no new capture occurs.
  - On out_ready=1 with req!=0: in the same cycle, in_ready[w]=1 for the next winner, computed from the updated pointer (last=current sel). Capture it; stay in BUSY. This gives back-to-back transfers at 1 word per cycle.
  - On out_ready=1 with req=0: go to IDLE, out_valid<=0. ou1 keeps its last value.
- Latency: a req seen in IDLE at cycle N gives out_valid=1 at cycle N+1.
- Handshake rules:
  - in_ready depends combinationally on req, state and out_ready.
  - At most one bit of in_ready is ever set.
  - Requesters must hold req and data until they see in_ready.
- Fairness: under continuous req=4'b1111, grants rotate 0,1,2,3,0,... A requester waits at most 3 grants.
- Simultaneous events: a requester that deasserts req in the same cycle it would have won is skipped. The scan simply picks the next set bit.
- Reset mid-transfer clears everything immediately. The first grant after reset goes to the lowest set req index.

Optional Feature:
ARB_STATS_EN:
- When defined, adds output grant_cnt (4x8 bits, packed 32 bits, requester k at bits [8k+7:8k]).
- Each field increments on every in_ready[k] pulse and wraps 255->0.
- All fields clear on reset.
- When undefined, the port and its counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/header mux4_arb_pkg holds:
  - the state encodings IDLE=1'b0 and BUSY=1'b1;
  - the constant NREQ=4;
  - the reset pointer value 2'd3.
- One sub-module, rr_pick4: combinational input (req[3:0], last[1:0]), outputs (any, w[1:0]).
- The data mux is instantiated as the existing mux4_1_v3 with .Width(Width), driven by the winner index.

Test Plan:
1. Reset: rst_n=0 mid-BUSY -> out_valid=0, ou1=0, sel=3, in_ready=0 immediately, without waiting for a clock edge.
2. Single requester: in1..in4=1,2,3,4, req=4'b0100, out_ready=1 -> in_ready=4'b0100 pulse, next cycle ou1=3, sel=2, out_valid=1.
3. Rotation: req=4'b1111 held, out_ready=1 for 8 cycles -> captured sequence sel=0,1,2,3,0,1,2,3 and ou1=1,2,3,4,1,2,3,4, one word per cycle.
4. Backpressure: BUSY with ou1=2, out_ready=0 for 5 cycles, req=4'b1111 -> ou1, sel and out_valid stable, in_ready=0. Release out_ready -> next grant sel=2.
5. Skip and wrap: last=2, req=4'b0011 -> winner 0 then 1. Then req=0 -> IDLE, out_valid=0 after the final accept.
6. With ARB_STATS_EN: 300 grants to requester 1 only -> grant_cnt[15:8]=44, the other fields 0.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared definitions for the round-robin 4:1 word arbiter.
//   arb_state_t : sequencer states (IDLE / BUSY)
//   NREQ        : number of requesters
//   PTR_RST     : round-robin pointer value after reset (requester 0 wins first)
//   onehot4     : 2-bit index -> 4-bit one-hot
package mux4_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int         NREQ    = 4;
  localparam logic [1:0] PTR_RST = 2'd3;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_1_v3.sv
// mux4_1_v3: plain combinational 4:1 word multiplexer.
// Ports:
//   in1..in4 : input words 0..3
//   sel      : selects in(sel+1)
//   ou1      : selected word
module mux4_1_v3 #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] in1,
  input  logic [Width-1:0] in2,
  input  logic [Width-1:0] in3,
  input  logic [Width-1:0] in4,
  input  logic [1:0]       sel,
  output logic [Width-1:0] ou1
);

  always_comb begin
    unique case (sel)
      2'd0:    ou1 = in1;
      2'd1:    ou1 = in2;
      2'd2:    ou1 = in3;
      default: ou1 = in4;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin winner selection for four requesters.
// Ports:
//   req  : request vector
//   last : index of the previous winner; the scan starts at last+1 and wraps
//   any  : at least one request is set
//   w    : winning index (equals last when any=0)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            any,
  output logic [1:0]      w
);

  // The 2-bit add wraps naturally; offset 4 lands back on last itself,
  // so the previous winner has lowest priority.
  always_comb begin
    any = 1'b0;
    w   = last;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[last + 2'(i)]) begin
        any = 1'b1;
        w   = last + 2'(i);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a shared 4:1 word mux.
// Four requesters compete for one output register which is presented
// downstream with a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   req[3:0]    : requester k holds a word on in(k+1)
//   in1..in4    : requester data words
//   in_ready    : one-hot accept pulse; word k is consumed when in_ready[k]=1
//   ou1         : registered output word
//   out_valid   : ou1 holds a word not yet accepted
//   out_ready   : consumer accepts ou1 when out_valid=1
//   sel         : index of the current / last granted requester (registered)
//   grant_cnt   : (only with ARB_STATS_EN) 4x8-bit wrapping grant counters,
//                 requester k at bits [8k+7:8k]
// Configuration macro: ARB_STATS_EN adds grant_cnt.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// 1. Upstream: in_ready[k] is the ready for req[k]; requesters hold req and data
// until they see it. Downstream: out_valid/ou1 stay stable until out_ready=1.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [Width-1:0] in1,
  input  logic [Width-1:0] in2,
  input  logic [Width-1:0] in3,
  input  logic [Width-1:0] in4,
  output logic [3:0]       in_ready,
  output logic [Width-1:0] ou1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel
`ifdef ARB_STATS_EN
  ,
  output logic [8*NREQ-1:0] grant_cnt
`endif
);

  arb_state_t       state;
  logic [1:0]       last;
  logic             any;
  logic [1:0]       w;
  logic             take;
  logic [Width-1:0] mux_word;

  // The round-robin pointer is always the last granted index, i.e. sel.
  assign last = sel;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .any  (any),
    .w    (w)
  );

  mux4_1_v3 #(.Width(Width)) u_mux (
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .sel (w),
    .ou1 (mux_word)
  );

  // A new word can be captured when the output register is empty or is being
  // drained this cycle. rst_n gates it so in_ready is 0 while reset is held.
  assign take      = rst_n && any && (state == IDLE || out_ready);
  assign in_ready  = take ? onehot4(w) : '0;
  assign out_valid = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ou1   <= '0;
      sel   <= PTR_RST;
    end else begin
      if (take) begin
        state <= BUSY;
        ou1   <= mux_word;
        sel   <= w;
      end else if (state == BUSY && out_ready) begin
        state <= IDLE;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) cnt[k] <= 8'd0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (in_ready[k]) cnt[k] <= cnt[k] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[8*g +: 8] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] in1, in2, in3, in4;
  logic [3:0]   in_ready;
  logic [W-1:0] ou1;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   sel;
`ifdef ARB_STATS_EN
  logic [31:0]  grant_cnt;
`endif

  mux4_rr_arbiter #(.Width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in_ready  (in_ready),
    .ou1       (ou1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model + scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];   // words captured but not yet accepted downstream
  int           m_last;     // previous winner index 0..3
  bit           m_busy;     // output register holds an unaccepted word
  logic [W-1:0] m_word;
  int           m_sel;
  int           m_cnt[4];

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 3;
    m_busy = 1'b0;
    m_word = '0;
    m_sel  = 3;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    exp_q.delete();
  endtask

  task automatic check_stats();
`ifdef ARB_STATS_EN
    for (int k = 0; k < 4; k++)
      chk($sformatf("grant_cnt[%0d]", k), 32'(grant_cnt[8*k +: 8]), 32'(m_cnt[k] % 256));
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, check #1 later, advance the model to
  // the state it will have after the following posedge.
  task automatic step(input logic [3:0] r, input logic ordy, input bit rnd_data);
    int           win;
    logic [W-1:0] d[4];
    logic [3:0]   exp_ir;
    @(negedge clk);
    req       = r;
    out_ready = ordy;
    if (rnd_data) begin
      in1 = W'($urandom); in2 = W'($urandom);
      in3 = W'($urandom); in4 = W'($urandom);
    end
    #1;
    d[0] = in1; d[1] = in2; d[2] = in3; d[3] = in4;
    win    = (!m_busy || ordy) ? pick(r, m_last) : -1;
    exp_ir = (win >= 0) ? 4'(1 << win) : 4'b0000;
    chk("in_ready",  32'(in_ready),  32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("ou1",       32'(ou1),       32'(m_word));
    chk("sel",       32'(sel),       32'(m_sel));
    if (m_busy && ordy) begin
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("accepted_word", 32'(ou1), 32'(exp_q.pop_front()));
    end
    if (win >= 0) begin
      m_word = d[win];
      m_sel  = win;
      m_last = win;
      m_busy = 1'b1;
      m_cnt[win]++;
      exp_q.push_back(d[win]);
    end else if (m_busy && ordy) begin
      m_busy = 1'b0;
    end
  endtask

  // Asserts reset between clock edges and checks it takes effect at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ou1",       32'(ou1),       32'd0);
    chk("rst_sel",       32'(sel),       32'd3);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    check_stats();
    req       = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_data();
    in1 = W'(1); in2 = W'(2); in3 = W'(3); in4 = W'(4);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    set_data();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single requester
    step(4'b0100, 1'b1, 0);
    chk("single_in_ready", 32'(in_ready), 32'h4);
    step(4'b0000, 1'b1, 0);
    chk("single_ou1", 32'(ou1), 32'd3);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_valid", 32'(out_valid), 32'd1);

    // Reset while BUSY with requests pending
    step(4'b1111, 1'b0, 0);
    step(4'b1111, 1'b0, 0);
    req = 4'b1111;
    do_reset();

    // Rotation under continuous requests
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, 0);
      chk("rot_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      if (i > 0) begin
        chk("rot_sel", 32'(sel), 32'((i - 1) % 4));
        chk("rot_ou1", 32'(ou1), 32'((i - 1) % 4 + 1));
      end
    end
    step(4'b0000, 1'b1, 0);
    chk("rot_last_sel", 32'(sel), 32'd3);
    chk("rot_last_ou1", 32'(ou1), 32'd4);

    // Backpressure
    do_reset();
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_ou1", 32'(ou1), 32'd2);
      chk("bp_sel", 32'(sel), 32'd1);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    step(4'b1111, 1'b1, 0);
    chk("bp_release_in_ready", 32'(in_ready), 32'h4);
    step(4'b0000, 1'b1, 0);
    chk("bp_release_sel", 32'(sel), 32'd2);

    // Skip and wrap from last=2, then drain to IDLE
    do_reset();
    step(4'b0100, 1'b1, 0);
    step(4'b0011, 1'b1, 0);
    chk("wrap_first", 32'(in_ready), 32'h1);
    step(4'b0011, 1'b1, 0);
    chk("wrap_second", 32'(in_ready), 32'h2);
    step(4'b0000, 1'b1, 0);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    chk("drain_valid_before", 32'(out_valid), 32'd1);
    step(4'b0000, 1'b1, 0);
    chk("drain_valid_after", 32'(out_valid), 32'd0);
    chk("drain_ou1_kept", 32'(ou1), 32'd2);

`ifdef ARB_STATS_EN
    // 300 grants to requester 1 wraps its counter to 44
    do_reset();
    for (int i = 0; i < 300; i++) step(4'b0010, 1'b1, 0);
    chk("stats_r1", 32'(grant_cnt[15:8]), 32'd44);
    chk("stats_others", 32'({grant_cnt[31:16], grant_cnt[7:0]}), 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1);
    end
    step(4'b0000, 1'b1, 0);
    check_stats();
    step(4'b0000, 1'b1, 0);
    chk("final_idle", 32'(out_valid), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
